// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Streams a program image into the CPU's program memory while holding the
//   CPU in reset. The CPU stays in reset for a settling period after the last
//   write, and is then released.
//
//   Ports
//     clk         sole clock, rising edge
//     rst         synchronous active-high reset, forces IDLE
//     start       begin a load (acted on in IDLE and RUN only)
//     in_valid    source presents a word on in_data
//     in_data     16-bit instruction word
//     in_last     in_data is the final word of the image
//     in_ready    loader accepts a beat this cycle (LOAD only)
//     pm_we       program-memory write strobe (one cycle after acceptance)
//     pm_addr     program-memory word address
//     pm_wdata    program-memory write data
//     cpu_rst     CPU core reset, low only in RUN
//     busy        high in LOAD and HOLD
//     done        one-cycle pulse in the first RUN cycle
//     err_ovf     sticky: image was longer than the memory
//     word_count  words written by the current/last load
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W   = 8,
    parameter int HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [15:0]       pm_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    // Value of the HOLD counter in the final HOLD cycle.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [3:0]        r_hold_cnt;
    logic              r_err_ovf;
    logic              r_pm_we;
    logic [ADDR_W-1:0] r_pm_addr;
    logic [15:0]       r_pm_wdata;
    logic              r_done;

    logic              w_accept;
    logic              w_at_top;
    logic              w_load_entry;
    logic              w_hold_end;

    // in_ready is exactly "state is LOAD", so a beat is accepted whenever the
    // source is valid while we are in LOAD.
    assign w_accept     = (r_state == S_LOAD) && in_valid;
    assign w_at_top     = (r_addr == {ADDR_W{1'b1}});
    assign w_load_entry = ((r_state == S_IDLE) || (r_state == S_RUN)) && start;
    assign w_hold_end   = (r_state == S_HOLD) && (r_hold_cnt == HOLD_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        cpu_rst      = 1'b1;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // The top word is always the last one written, whether or
                // not the source flagged it as last.
                if (w_accept && (in_last || w_at_top)) w_state_next = S_HOLD;
            end
            S_HOLD: begin
                busy = 1'b1;
                if (w_hold_end) w_state_next = S_RUN;
            end
            S_RUN: begin
                cpu_rst = 1'b0;
                if (start) w_state_next = S_LOAD;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: write port, address/word counters, hold timer, flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_count    <= '0;
            r_hold_cnt <= '0;
            r_err_ovf  <= 1'b0;
            r_pm_we    <= 1'b0;
            r_pm_addr  <= '0;
            r_pm_wdata <= '0;
            r_done     <= 1'b0;
        end else begin
            r_pm_we <= w_accept;
            r_done  <= w_hold_end;

            if (r_state == S_HOLD) begin
                r_hold_cnt <= r_hold_cnt + 4'd1;
            end else begin
                r_hold_cnt <= '0;
            end

            if (w_accept) begin
                r_pm_addr  <= r_addr;
                r_pm_wdata <= in_data;
                r_addr     <= r_addr + 1'b1;
                r_count    <= r_count + 1'b1;
                if (w_at_top && !in_last) r_err_ovf <= 1'b1;
            end

            // Mutually exclusive with w_accept (different states).
            if (w_load_entry) begin
                r_addr    <= '0;
                r_count   <= '0;
                r_err_ovf <= 1'b0;
            end
        end
    end

    assign pm_we      = r_pm_we;
    assign pm_addr    = r_pm_addr;
    assign pm_wdata   = r_pm_wdata;
    assign done       = r_done;
    assign err_ovf    = r_err_ovf;
    assign word_count = r_count;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, program-memory word-address width (depth 2**ADDR_W words).
REQ-002 Parameter HOLD_CYC, default 4, cycles the CPU reset is held after the last write (legal 1..15).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  begin a load; sampled only in IDLE and RUN.
REQ-006 in_valid  in  1  source has a program word on in_data.
REQ-007 in_data  in  16  instruction word.
REQ-008 in_last  in  1  qualifies in_data as the final word of the image.
REQ-009 in_ready  out  1  loader accepts a beat this cycle.
REQ-010 pm_we  out  1  program-memory write strobe.
REQ-011 pm_addr  out  ADDR_W  program-memory word address.
REQ-012 pm_wdata  out  16  program-memory write data.
REQ-013 cpu_rst  out  1  reset to the CPU core, active-high.
REQ-014 busy  out  1  high in LOAD and HOLD.
REQ-015 done  out  1  one-cycle pulse when the CPU is released.
REQ-016 err_ovf  out  1  sticky: image exceeded memory depth.
REQ-017 word_count  out  ADDR_W+1  words written by the current/last load.

Function
REQ-018 States SHALL be IDLE, LOAD, HOLD, RUN, encoded in registers.
REQ-019 IDLE: cpu_rst=1, in_ready=0; start=1 -> LOAD.
REQ-020 Entering LOAD SHALL clear the address counter, word_count and err_ovf.
REQ-021 LOAD: in_ready=1, cpu_rst=1; beat accepted iff in_valid & in_ready.
REQ-022 Each accepted beat SHALL produce, on the next cycle, pm_we=1, pm_addr=current counter, pm_wdata=in_data for exactly one cycle (latency 1, registered outputs).
REQ-023 The address counter and word_count SHALL increment by 1 per accepted beat.
REQ-024 Accepted beat with in_last=1 -> HOLD; in_ready SHALL be 0 from the following cycle.
REQ-025 Accepted beat at address 2**ADDR_W-1 with in_last=0 -> HOLD with err_ovf=1; the word is still written; no further beats accepted.
REQ-026 in_last=1 at address 2**ADDR_W-1 SHALL NOT set err_ovf.
REQ-027 in_valid=0 in LOAD SHALL stall indefinitely with no write and no state change.
REQ-028 HOLD: in_ready=0, cpu_rst=1 for exactly HOLD_CYC cycles, then -> RUN.
REQ-029 HOLD->RUN transition: cpu_rst=0 from the first RUN cycle; done=1 in that same cycle only.
REQ-030 RUN: cpu_rst=0, in_ready=0; start=1 -> LOAD with cpu_rst=1 on the next cycle (reload).
REQ-031 start in LOAD or HOLD SHALL be ignored.
REQ-032 word_count and err_ovf SHALL hold their values in HOLD, RUN and IDLE until the next LOAD entry.
REQ-033 pm_we SHALL never be 1 outside the cycle following an accepted beat.

Reset
REQ-034 rst=1 at any edge SHALL force IDLE regardless of state, including mid-LOAD or mid-HOLD.
REQ-035 Reset values: cpu_rst=1, in_ready=0, pm_we=0, pm_addr=0, pm_wdata=0, busy=0, done=0, err_ovf=0, word_count=0.
REQ-036 A beat presented in the cycle rst=1 SHALL NOT be written.

Verification
REQ-037 Reset, start, 3 beats 0x1111/0x2222/0x3333 (last on third) -> writes addr 0,1,2 each 1 cycle after accept; word_count=3; cpu_rst falls 4 cycles after HOLD entry; done pulses once.
REQ-038 Same image with in_valid toggled 1/0 each cycle -> identical memory writes, no extra pm_we, in_ready held 1 throughout LOAD.
REQ-039 ADDR_W=2, 5 beats without in_last -> 4 writes (addr 0..3), err_ovf=1, 5th beat not accepted (in_ready=0), CPU released normally.
REQ-040 ADDR_W=2, 4 beats with in_last on 4th -> err_ovf=0, word_count=4.
REQ-041 rst asserted after 2 of 5 beats -> IDLE, cpu_rst=1, no write for the in-flight beat; new start reloads from addr 0.
REQ-042 In RUN assert start -> cpu_rst=1 next cycle, word_count and err_ovf cleared, reload of 1 word 0xABCD writes addr 0.
